bsg_buf_arb_rr: RTL
===================

BSG_BUF_ARB_RR -- requirements
Module: bsg_buf_arb_rr

Interface
REQ-001 Parameter width_p, default 64, SHALL set the bit width of each requester word and of the output word.
REQ-002 Parameter els_p, default 4, SHALL set the number of requesters and SHALL be at least 1.
REQ-003 Derived tag width SHALL be safe-clog2(els_p), with a minimum of 1.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  SHALL be the reset: synchronous and active-high.
REQ-006 v_i  input  els_p  SHALL be the per-requester valid bits.
REQ-007 data_i  input  els_p*width_p  SHALL carry the requester words; requester k occupies bits [k*width_p +: width_p].
REQ-008 yumi_o  output  els_p  SHALL be the per-requester dequeue acknowledge; it is at most one-hot.
REQ-009 v_o  output  1  SHALL indicate that the output word is valid.
REQ-010 data_o  output  width_p  SHALL be the registered output word.
REQ-011 tag_o  output  tag width  SHALL be the index of the requester whose word is in data_o.
REQ-012 ready_i  input  1  SHALL be the consumer ready; a transfer occurs when v_o & ready_i.

Function
REQ-013 The output stage SHALL be a single registered slot (v_o, data_o, tag_o), with slot_free = ~v_o | ready_i.
REQ-014 When slot_free is high and any v_i bit is set, the block SHALL grant exactly one requester g in the same cycle.
REQ-015 Grant selection SHALL search round-robin, starting at pointer ptr and ascending modulo els_p.
REQ-016 On a grant, yumi_o[g] SHALL be 1 combinationally in that cycle.
- Next edge: data_o <= data_i[g], tag_o <= g, v_o <= 1.
- Latency: 1 cycle.
REQ-017 After a grant, ptr SHALL become (g+1) mod els_p; with no grant, ptr SHALL hold.
REQ-018 When slot_free is high and v_i is all zero, yumi_o SHALL be 0 and v_o SHALL be 0 at the next edge.
REQ-019 When v_o=1 and ready_i=0 (stall), yumi_o SHALL be 0 and v_o, data_o and tag_o SHALL hold stable.
REQ-020 With ready_i held at 1 and requests present, the block SHALL sustain one word per cycle (full throughput, no bubble).
REQ-021 yumi_o[k] SHALL never assert unless v_i[k]=1; yumi_o SHALL depend on v_i, ptr, v_o and ready_i only, never on data_i.
REQ-022 Requesters hold data_i[k] and v_i[k] until yumi_o[k]; the block SHALL tolerate v_i changing in any cycle without a yumi.
REQ-023 Fairness: a requester continuously asserting v_i SHALL be granted within els_p grants.
REQ-024 With els_p=1, ptr SHALL be constant 0 and tag_o SHALL always be 0.

Reset
REQ-025 While reset_i=1, yumi_o SHALL be 0 and no grant SHALL occur.
REQ-026 At the edge with reset_i=1, the block SHALL set v_o=0, data_o=0, tag_o=0 and ptr=0.
REQ-027 Reset mid-operation SHALL discard any buffered word without a transfer.
REQ-028 In the first cycle after reset is released, the block SHALL be able to grant, giving priority to requester 0.

Structure
REQ-029 The tag-width computation and the package-level defaults for width_p/els_p SHALL live in the shared package bsg_buf_arb_pkg.
REQ-030 Round-robin selection SHALL be a sub-module, bsg_arb_round_robin (inputs: requests, pointer; outputs: one-hot grant, grant index).
REQ-031 The top module SHALL contain only the output slot, the ptr register and the handshake logic; there SHALL be no latches.

Verification (width_p=64, els_p=4)
REQ-032 Reset release, v_i=4'b1111 with data k=64'h0..0k, ready_i=1:
- yumi_o sequence 0001,0010,0100,1000,0001.
- tag_o sequence 0,1,2,3,0, each 1 cycle after its yumi.
REQ-033 v_i=4'b0100, ready_i=0 for 5 cycles after the first grant:
- yumi_o = 0100 once only.
- data_o = word 2 held stable with v_o=1.
- On release: one transfer, then v_o=0.
REQ-034 Simultaneous dequeue and grant (v_o=1, ready_i=1, v_i=4'b0011, ptr=1):
- yumi_o=0010 in the same cycle.
- Next cycle: tag_o=1, ptr=2.
REQ-035 Assert reset_i while v_o=1, ready_i=0, tag_o=3:
- Next cycle: v_o=0, tag_o=0, data_o=0.
- No yumi_o during reset.
- First post-reset grant goes to the lowest set v_i.
REQ-036 Random v_i/ready_i for 10k cycles with a scoreboard:
- Every yumi'd word appears exactly once, in grant order.
- yumi_o is never multi-hot.
- Starvation bound of 4 grants holds.

Source files
------------

// File: rtl/bsg_buf_arb_pkg.sv
// bsg_buf_arb_pkg
//   Shared definitions for the buffered round-robin arbiter slice:
//   default word width and requester count, plus the tag-width helper
//   used by the interface, the arbiter core and the top level.
//   No ports (package).

package bsg_buf_arb_pkg;

  localparam int width_default_lp = 64;
  localparam int els_default_lp   = 4;

  // Width of an index into els requesters. It is never narrower than one
  // bit, so a single-requester build still has a usable tag/pointer field.
  function automatic int safe_clog2(input int els);
    return (els <= 1) ? 1 : $clog2(els);
  endfunction

endpackage

// File: rtl/bsg_buf_arb_rr_if.sv
// bsg_buf_arb_rr_if
//   Bundles the requester side and the consumer side of the buffered
//   round-robin arbiter.
//   Signals:
//     v_i     [els_p]          per-requester valid
//     data_i  [els_p*width_p]  requester words, requester k at [k*width_p +: width_p]
//     yumi_o  [els_p]          per-requester dequeue acknowledge (at most one-hot)
//     v_o                      output word valid
//     data_o  [width_p]        registered output word
//     tag_o   [tag width]      index of the requester that supplied data_o
//     ready_i                  consumer ready; a transfer happens on v_o & ready_i
//   Modports:
//     slave   the arbiter itself
//     master  the environment driving requesters and the consumer

interface bsg_buf_arb_rr_if
  import bsg_buf_arb_pkg::*;
#(
  parameter int width_p = width_default_lp,
  parameter int els_p   = els_default_lp
);

  localparam int tag_width_lp = safe_clog2(els_p);

  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         yumi_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic [tag_width_lp-1:0]  tag_o;
  logic                     ready_i;

  modport slave (
    input  v_i, data_i, ready_i,
    output yumi_o, v_o, data_o, tag_o
  );

  modport master (
    output v_i, data_i, ready_i,
    input  yumi_o, v_o, data_o, tag_o
  );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin
//   Purely combinational round-robin selector. Searches the request vector
//   starting at ptr_i and ascending modulo els_p; the first set request wins.
//   Ports:
//     reqs_i       [els_p]      request bits
//     ptr_i        [tag width]  index where the search starts
//     grant_o      [els_p]      one-hot grant (all zero when nothing requests)
//     grant_idx_o  [tag width]  index of the granted requester (0 if none)
//     v_o                       a request was found

module bsg_arb_round_robin
  import bsg_buf_arb_pkg::*;
#(
  parameter int els_p = els_default_lp,
  localparam int tag_width_lp = safe_clog2(els_p)
) (
  input  logic [els_p-1:0]        reqs_i,
  input  logic [tag_width_lp-1:0] ptr_i,
  output logic [els_p-1:0]        grant_o,
  output logic [tag_width_lp-1:0] grant_idx_o,
  output logic                    v_o
);

  // Walk every requester once, beginning at the pointer; once v_o is set
  // later candidates are ignored, so the grant stays one-hot.
  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    v_o         = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= els_p) idx = idx - els_p;
      if (!v_o && reqs_i[idx]) begin
        v_o          = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = tag_width_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bsg_buf_arb_rr.sv
// bsg_buf_arb_rr
//   Round-robin arbiter feeding a single registered output slot. A requester
//   is granted (yumi_o) in the same cycle the slot can accept a word; the word
//   appears on data_o/tag_o one cycle later. The slot refills in the same
//   cycle it is drained, so a held ready_i gives one word per cycle.
//   Ports:
//     clk_i    clock, all state on the rising edge
//     reset_i  synchronous active-high reset
//     bus      bsg_buf_arb_rr_if.slave (v_i, data_i, yumi_o, v_o, data_o,
//              tag_o, ready_i)

module bsg_buf_arb_rr
  import bsg_buf_arb_pkg::*;
#(
  parameter int width_p = width_default_lp,
  parameter int els_p   = els_default_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  bsg_buf_arb_rr_if.slave    bus
);

  localparam int tag_width_lp = safe_clog2(els_p);

  logic [tag_width_lp-1:0] ptr_r;
  logic [tag_width_lp-1:0] ptr_n;
  logic                    v_r;
  logic [width_p-1:0]      data_r;
  logic [tag_width_lp-1:0] tag_r;

  logic                    slot_free;
  logic                    arb_v;
  logic                    grant_v;
  logic [els_p-1:0]        grant_oh;
  logic [tag_width_lp-1:0] grant_idx;

  bsg_arb_round_robin #(
    .els_p (els_p)
  ) arb (
    .reqs_i      (bus.v_i),
    .ptr_i       (ptr_r),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .v_o         (arb_v)
  );

  // The slot can take a new word when it is empty or being drained this cycle.
  // Reset suppresses the grant so no requester is dequeued into a slot that
  // is about to be cleared.
  assign slot_free  = ~v_r | bus.ready_i;
  assign grant_v    = arb_v & slot_free & ~reset_i;
  assign bus.yumi_o = grant_v ? grant_oh : '0;

  // Pointer advances to just past the winner, wrapping at els_p. With a
  // single requester the winner is always index 0, so this is constant 0.
  always_comb begin
    ptr_n = '0;
    if (grant_idx != tag_width_lp'(els_p - 1)) ptr_n = grant_idx + 1'b1;
  end

  // Output slot and pointer. Data and tag only change on a grant, so a
  // stalled slot (v_r & ~ready_i) holds everything stable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
      tag_r  <= '0;
      ptr_r  <= '0;
    end else if (slot_free) begin
      v_r <= grant_v;
      if (grant_v) begin
        data_r <= bus.data_i[grant_idx*width_p +: width_p];
        tag_r  <= grant_idx;
        ptr_r  <= ptr_n;
      end
    end
  end

  assign bus.v_o    = v_r;
  assign bus.data_o = data_r;
  assign bus.tag_o  = tag_r;

endmodule
